// File: rtl/gpio_input_conditioner.sv
// Per-pin GPIO input conditioning: 2-flop synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
// registered level, single-cycle rise/fall pulses, sticky interrupt-pending flags and an OR'd irq.
module gpio_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_Pin,
  input  logic [WIDTH-1:0] i_RiseEn,
  input  logic [WIDTH-1:0] i_FallEn,
  input  logic [WIDTH-1:0] i_IrqClr,
  output logic [WIDTH-1:0] o_Level,
  output logic [WIDTH-1:0] o_Rise,
  output logic [WIDTH-1:0] o_Fall,
  output logic [WIDTH-1:0] o_Pending,
  output logic             o_Irq
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] pending_q, pending_d;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= i_Pin;
      s2_q <= s1_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];

  // Level follows s2 only after it has disagreed for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    // NOTE: defaults first on every path so no latch is inferred.
    level_d = level_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // NOTE: the counter array is reset explicitly; a mid-count reset must discard progress.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign level_d = s2_q;
`endif

  always_comb begin
    rise_d    = level_d & ~level_q;
    fall_d    = ~level_d & level_q;
    pending_d = (pending_q & ~i_IrqClr) | (rise_d & i_RiseEn) | (fall_d & i_FallEn);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      level_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pending_q <= '0;
    end else begin
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
    end
  end

  assign o_Level   = level_q;
  assign o_Rise    = rise_q;
  assign o_Fall    = fall_q;
  assign o_Pending = pending_q;
  assign o_Irq     = |pending_q;

endmodule

// File: doc/gpio_input_conditioner.md
# gpio_input_conditioner

Per-pin input conditioning stage between the asynchronous GPIO pads and the GPIO slave's input path. It synchronises each pin, optionally debounces it, and produces a clean level, single-cycle rise/fall pulses and sticky per-pin interrupt-pending flags. The GPIO slave reads `o_Level` as its input data register and exposes edge-enable, pending and clear controls on the bus.

## Interface

**Parameters**
- `WIDTH`, default 8: number of pins.
- `DEBOUNCE_CYCLES`, default 16, legal range ≥ 2: consecutive stable synchronised cycles required before `o_Level` follows.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

**Ports**
- `i_Clk`, input, 1: single clock; all logic on its rising edge.
- `i_Rst`, input, 1: reset, synchronous, active-low.
- `i_Pin`, input, `WIDTH`: raw asynchronous pad inputs.
- `i_RiseEn`, input, `WIDTH`: per-pin rising-edge interrupt enable.
- `i_FallEn`, input, `WIDTH`: per-pin falling-edge interrupt enable.
- `i_IrqClr`, input, `WIDTH`: write-1-to-clear pulse for `o_Pending`, one cycle.
- `o_Level`, output, `WIDTH`: conditioned pin level, registered.
- `o_Rise`, output, `WIDTH`: one-cycle pulse on a 0→1 change of `o_Level`, registered.
- `o_Fall`, output, `WIDTH`: one-cycle pulse on a 1→0 change of `o_Level`, registered.
- `o_Pending`, output, `WIDTH`: sticky interrupt-pending flags.
- `o_Irq`, output, 1: OR of `o_Pending` (combinational from registers).

## Operation

**Reset**
- With `i_Rst`=0 at a clock edge, every flop clears: sync stages, counters, `o_Level`, `o_Rise`, `o_Fall`, `o_Pending`.
- `o_Irq`=0.

**Per bit, independent**
- *Synchroniser:* two flops, `s1` ← `i_Pin`, `s2` ← `s1`.
- *Debouncer (macro enabled):*
  - `s2` == `o_Level`: counter ← 0.
  - `s2` != `o_Level` and counter < `DEBOUNCE_CYCLES-1`: counter increments.
  - `s2` != `o_Level` and counter == `DEBOUNCE_CYCLES-1`: `o_Level` ← `s2`, counter ← 0.
  - A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles resets the count and never reaches `o_Level`.
- *Edge pulses:*
  - `o_Rise` is set on the same edge `o_Level` goes 0→1, and `o_Fall` on the same edge it goes 1→0.
  - Both are cleared on every other edge. They are never both high.
- *Pending flags:*
  - Next value = (`o_Pending` & ~`i_IrqClr`) | (rise_event & `i_RiseEn`) | (fall_event & `i_FallEn`).
  - rise_event and fall_event are the conditions that set `o_Rise`/`o_Fall` on this edge.
  - If a set and a clear occur on the same edge, set wins.
  - An enable deasserted later does not clear an already-set pending bit.

**Boundary conditions**
- Pin held high through reset release: `o_Level` rises after the normal latency, producing an `o_Rise` pulse and pending if `i_RiseEn`.
- Reset asserted mid-count: the count is lost and no pulse is produced.
- Pin toggling faster than the debounce window: `o_Level` holds.

## Timing

- Pin change first captured by `s1` at edge k; `s2` holds the new value from edge k+1.
- **Debounce enabled:**
  - `o_Level`, `o_Rise`/`o_Fall` update at edge k+1+`DEBOUNCE_CYCLES`.
  - `o_Pending` updates on that same edge.
  - `o_Irq` is high in the following cycle, with no added delay after `o_Pending`.
- **Debounce disabled:** `o_Level` ← `s2` every edge; update at edge k+2.
- Clear latency: `i_IrqClr` high at edge n ⇒ `o_Pending` bit 0 after edge n, unless a new event coincides.
- No backpressure or handshakes; a new edge event is accepted every cycle.

## Configuration

- Macro `GPIO_DEBOUNCE_EN`.
  - **Defined:** debounce counters are present and behave as above.
  - **Undefined:** counters are removed, `DEBOUNCE_CYCLES` is ignored, and `o_Level` is `s2` delayed one register (latency 2 cycles).
- Edge, pending and interrupt logic are identical in both builds.

## Test plan

All scenarios use `WIDTH`=8 and `DEBOUNCE_CYCLES`=4 with the macro defined, unless stated.

- **Reset:** `i_Rst`=0 for 2 cycles with `i_Pin`=8'hFF → all outputs 0 during reset. After release, `o_Level`=8'hFF at edge 5, `o_Rise`=8'hFF for exactly that one cycle.
- **Clean edge with interrupt:** `i_RiseEn`=8'h01; `i_Pin[0]` 0→1 held → `o_Level[0]`=1 and `o_Rise[0]` pulse at edge k+5, `o_Pending`=8'h01, `o_Irq`=1. `i_IrqClr`=8'h01 for one cycle → `o_Pending`=0, `o_Irq`=0.
- **Glitch rejection:** `i_Pin[3]` high for 3 cycles then low → `o_Level[3]` stays 0, no `o_Rise[3]`. Held 4+ synchronised cycles → rises.
- **Fall enable only:** `i_FallEn`=8'h80, `i_RiseEn`=0; `i_Pin[7]` rises then falls → `o_Rise[7]` pulse with no pending. On the fall, `o_Fall[7]` pulse and `o_Pending`=8'h80.
- **Set/clear collision:** `i_IrqClr[2]`=1 on the same edge a rising event on pin 2 with `i_RiseEn[2]`=1 fires → `o_Pending[2]` remains 1.
- **Macro undefined build:** `i_Pin` 8'h00→8'h55 → `o_Level`=8'h55 and `o_Rise`=8'h55 at edge k+2; a 1-cycle glitch propagates as a 1-cycle `o_Level` pulse.
